// File: rtl/regfile_dbg_pkg.sv
// Shared definitions for the register-file debug dump engine: FSM state
// encoding, byte-source select codes and frame geometry.
package regfile_dbg_pkg;

    localparam int unsigned REG_ADDR_W    = 5;
    localparam int unsigned DATA_W        = 32;
    localparam int unsigned BYTE_W        = 8;
    localparam int unsigned CNT_W         = 2;
    localparam int unsigned BYTES_PER_REG = 5;
    localparam logic [2:0]  HDR_TAG_DEFAULT = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_HDR,
        ST_DATA,
        ST_SUM,
        ST_DONE
    } state_e;

    // Which source drives the outgoing byte
    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_HDR,
        SEL_DATA,
        SEL_SUM
    } byte_sel_e;

endpackage

// File: rtl/dump_byte_sel.sv
// Byte-select mux and checksum accumulator for the dump stream.
// Ports:
//   sel        - byte source (byte_sel_e code)
//   snapshot   - captured 32-bit register value
//   count      - data byte index, 0 selects [31:24]
//   header     - per-register header byte
//   checksum   - current running checksum
//   clear      - restart the checksum
//   acc        - fold acc_byte into the checksum
//   acc_byte   - byte just accepted by the sink
//   checksum_c - next checksum value
//   byte_c     - selected stream byte (checksum source sees checksum_c)
module dump_byte_sel
    import regfile_dbg_pkg::*;
(
    input  logic [1:0]        sel,
    input  logic [DATA_W-1:0] snapshot,
    input  logic [CNT_W-1:0]  count,
    input  logic [BYTE_W-1:0] header,
    input  logic [BYTE_W-1:0] checksum,
    input  logic              clear,
    input  logic              acc,
    input  logic [BYTE_W-1:0] acc_byte,
    output logic [BYTE_W-1:0] checksum_c,
    output logic [BYTE_W-1:0] byte_c
);

    // Running XOR of every accepted byte
    always_comb begin
        checksum_c = checksum;
        if (clear) begin
            checksum_c = '0;
        end else if (acc) begin
            checksum_c = checksum ^ acc_byte;
        end
    end

    // Source mux; data bytes go out MSB first
    always_comb begin
        byte_c = '0;
        case (sel)
            SEL_HDR:  byte_c = header;
            SEL_DATA: begin
                case (count)
                    2'd0:    byte_c = snapshot[31:24];
                    2'd1:    byte_c = snapshot[23:16];
                    2'd2:    byte_c = snapshot[15:8];
                    default: byte_c = snapshot[7:0];
                endcase
            end
            SEL_SUM:  byte_c = checksum_c;
            default:  byte_c = '0;
        endcase
    end

endmodule

// File: rtl/regfile_dump.sv
// Debug readout engine: on start, walks registers FIRST_REG..LAST_REG through
// a dedicated regfile read port and streams each as a 5-byte frame
// (header {HDR_TAG, idx}, data MSB first), followed by one XOR checksum byte.
// Ports:
//   clock, ctrl_reset - clock and asynchronous active-high reset
//   start             - request a dump (only honoured when idle)
//   ctrl_readReg      - regfile read address
//   data_readReg      - regfile read data (combinational from ctrl_readReg)
//   tx_data/tx_valid/tx_ready - byte stream, accepted on valid && ready
//   busy              - dump in progress
//   done              - one-cycle pulse after the checksum byte is accepted
module regfile_dump
    import regfile_dbg_pkg::*;
#(
    parameter int unsigned FIRST_REG = 0,
    parameter int unsigned LAST_REG  = 31,
    parameter logic [2:0]  HDR_TAG   = HDR_TAG_DEFAULT
) (
    input  logic                  clock,
    input  logic                  ctrl_reset,
    input  logic                  start,
    output logic [REG_ADDR_W-1:0] ctrl_readReg,
    input  logic [DATA_W-1:0]     data_readReg,
    output logic [BYTE_W-1:0]     tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic                  done
);

    if (FIRST_REG > LAST_REG || LAST_REG > 31) begin : g_bad_range
        $error("regfile_dump: need FIRST_REG <= LAST_REG <= 31");
    end

    localparam logic [REG_ADDR_W-1:0] FIRST_IDX = REG_ADDR_W'(FIRST_REG);
    localparam logic [REG_ADDR_W-1:0] LAST_IDX  = REG_ADDR_W'(LAST_REG);
    localparam logic [CNT_W-1:0]      LAST_CNT  = CNT_W'(BYTES_PER_REG - 2);

    state_e                state, state_n;
    logic [REG_ADDR_W-1:0] index, index_n;
    logic [CNT_W-1:0]      count, count_n;
    logic [DATA_W-1:0]     snapshot, snapshot_n;
    logic [BYTE_W-1:0]     checksum, checksum_n;
    logic [BYTE_W-1:0]     tx_data_n;
    logic [1:0]            sel_n;
    logic                  clear_sum;
    logic                  acc_sum;
    logic                  handshake;

    assign handshake = tx_valid && tx_ready;

    // State and datapath registers
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            state    <= ST_IDLE;
            index    <= FIRST_IDX;
            count    <= '0;
            snapshot <= '0;
            checksum <= '0;
        end else begin
            state    <= state_n;
            index    <= index_n;
            count    <= count_n;
            snapshot <= snapshot_n;
            checksum <= checksum_n;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_n    = state;
        index_n    = index;
        count_n    = count;
        snapshot_n = snapshot;
        clear_sum  = 1'b0;
        acc_sum    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    index_n   = FIRST_IDX;
                    clear_sum = 1'b1;
                    state_n   = ST_ADDR;
                end
            end
            ST_ADDR: begin
                snapshot_n = data_readReg;
                state_n    = ST_HDR;
            end
            ST_HDR: begin
                if (handshake) begin
                    acc_sum = 1'b1;
                    count_n = '0;
                    state_n = ST_DATA;
                end
            end
            ST_DATA: begin
                if (handshake) begin
                    acc_sum = 1'b1;
                    count_n = count + CNT_W'(1);
                    if (count == LAST_CNT) begin
                        if (index == LAST_IDX) begin
                            state_n = ST_SUM;
                        end else begin
                            index_n = index + REG_ADDR_W'(1);
                            state_n = ST_ADDR;
                        end
                    end
                end
            end
            ST_SUM: begin
                if (handshake) begin
                    state_n = ST_DONE;
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Byte source follows the state being entered so outputs can be registered
    always_comb begin
        sel_n = SEL_NONE;
        case (state_n)
            ST_HDR:  sel_n = SEL_HDR;
            ST_DATA: sel_n = SEL_DATA;
            ST_SUM:  sel_n = SEL_SUM;
            default: sel_n = SEL_NONE;
        endcase
    end

    dump_byte_sel u_byte_sel (
        .sel        (sel_n),
        .snapshot   (snapshot_n),
        .count      (count_n),
        .header     ({HDR_TAG, index_n}),
        .checksum   (checksum),
        .clear      (clear_sum),
        .acc        (acc_sum),
        .acc_byte   (tx_data),
        .checksum_c (checksum_n),
        .byte_c     (tx_data_n)
    );

    // Registered outputs
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            ctrl_readReg <= '0;
            tx_data      <= '0;
            tx_valid     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            tx_data  <= tx_data_n;
            tx_valid <= (sel_n != SEL_NONE);
            busy     <= (state_n inside {ST_ADDR, ST_HDR, ST_DATA, ST_SUM});
            done     <= (state_n == ST_DONE);
            if (state_n == ST_ADDR) begin
                ctrl_readReg <= index_n;
            end
        end
    end

endmodule

// File: tb/tb_regfile_dump.sv
// Self-checking bench: lane 0 dumps a single register (FIRST=LAST=1),
// lane 1 uses default parameters. Expected frames are built from the regfile
// contents at start time and checked by a negedge monitor.
module tb_regfile_dump;

    localparam int NL = 2;

    logic        clock = 1'b0;
    logic        ctrl_reset;
    logic        start    [NL];
    logic [4:0]  rd_addr  [NL];
    logic [31:0] rd_data  [NL];
    logic [7:0]  tx_data  [NL];
    logic        tx_valid [NL];
    logic        tx_ready [NL];
    logic        busy     [NL];
    logic        done     [NL];

    logic [31:0] regs [NL][32];
    logic        bp [NL];

    logic [8:0]  exp_q0 [$];
    logic [8:0]  exp_q1 [$];

    int errors = 0;
    int checks = 0;
    int rx_count [NL];
    int done_due [NL];
    logic held [NL];
    logic [7:0] held_data [NL];

    always #5 clock = ~clock;

    assign rd_data[0] = (rd_addr[0] == 5'd0) ? 32'h0 : regs[0][rd_addr[0]];
    assign rd_data[1] = (rd_addr[1] == 5'd0) ? 32'h0 : regs[1][rd_addr[1]];

    regfile_dump #(.FIRST_REG(1), .LAST_REG(1)) dut_one (
        .clock(clock), .ctrl_reset(ctrl_reset), .start(start[0]),
        .ctrl_readReg(rd_addr[0]), .data_readReg(rd_data[0]),
        .tx_data(tx_data[0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
        .busy(busy[0]), .done(done[0])
    );

    regfile_dump dut_all (
        .clock(clock), .ctrl_reset(ctrl_reset), .start(start[1]),
        .ctrl_readReg(rd_addr[1]), .data_readReg(rd_data[1]),
        .tx_data(tx_data[1]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
        .busy(busy[1]), .done(done[1])
    );

    function automatic int first_of(int l);
        return (l == 0) ? 1 : 0;
    endfunction

    function automatic int last_of(int l);
        return (l == 0) ? 1 : 31;
    endfunction

    function automatic int qsize(int l);
        return (l == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    function automatic logic [8:0] pop_exp(int l);
        if (l == 0) return exp_q0.pop_front();
        return exp_q1.pop_front();
    endfunction

    task automatic push_exp(int l, logic [8:0] e);
        if (l == 0) exp_q0.push_back(e);
        else exp_q1.push_back(e);
    endtask

    task automatic check(string name, int l, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s lane%0d: got %0h, want %0h", name, l, act, exp);
        end
    endtask

    // Reference frame: header, 4 data bytes MSB first per register, then XOR of all
    task automatic push_frame(int l);
        logic [7:0]  sum;
        logic [7:0]  b;
        logic [31:0] v;
        sum = 8'h00;
        for (int r = first_of(l); r <= last_of(l); r++) begin
            v = (r == 0) ? 32'h0 : regs[l][r];
            b = {3'b101, 5'(r)};
            push_exp(l, {1'b0, b});
            sum = sum ^ b;
            for (int k = 3; k >= 0; k--) begin
                b = v[k*8 +: 8];
                push_exp(l, {1'b0, b});
                sum = sum ^ b;
            end
        end
        push_exp(l, {1'b1, sum});
    endtask

    // Random tx_ready (30% high) when backpressure is enabled
    initial begin
        for (int l = 0; l < NL; l++) tx_ready[l] = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            for (int l = 0; l < NL; l++)
                tx_ready[l] = bp[l] ? (($urandom_range(0, 99) < 30) ? 1'b1 : 1'b0) : 1'b1;
        end
    end

    // Scoreboard monitor
    always @(negedge clock) begin
        logic [8:0] e;
        for (int l = 0; l < NL; l++) begin
            if (ctrl_reset) begin
                held[l] = 1'b0;
                done_due[l] = 0;
                if (l == 0) exp_q0.delete();
                else exp_q1.delete();
            end else begin
                if (done_due[l] == 1) begin
                    check("done_pulse", l, done[l], 1'b1);
                    check("busy_in_done", l, busy[l], 1'b0);
                    done_due[l] = 2;
                end else if (done_due[l] == 2) begin
                    check("done_one_cycle", l, done[l], 1'b0);
                    done_due[l] = 0;
                end else if (done[l]) begin
                    checks++;
                    errors++;
                    $display("FAIL done_spurious lane%0d: got 1, want 0", l);
                end
                if (held[l]) begin
                    check("valid_held", l, tx_valid[l], 1'b1);
                    check("data_held", l, tx_data[l], held_data[l]);
                end
                if (tx_valid[l] && !busy[l]) begin
                    checks++;
                    errors++;
                    $display("FAIL busy_during_tx lane%0d: got 0, want 1", l);
                end
                if (tx_valid[l] && tx_ready[l]) begin
                    if (qsize(l) == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_byte lane%0d: got %0h, want none", l, tx_data[l]);
                    end else begin
                        e = pop_exp(l);
                        check("byte", l, tx_data[l], e[7:0]);
                        rx_count[l]++;
                        if (e[8]) done_due[l] = 1;
                    end
                    held[l] = 1'b0;
                end else begin
                    held[l] = tx_valid[l];
                    held_data[l] = tx_data[l];
                end
            end
        end
    end

    task automatic pulse_start(int l, bit accept);
        @(posedge clock);
        #1;
        start[l] = 1'b1;
        if (accept) push_frame(l);
        @(posedge clock);
        #1;
        start[l] = 1'b0;
    endtask

    task automatic wait_quiet(int l, int budget, string name);
        int n;
        n = 0;
        while (!(qsize(l) == 0 && done_due[l] == 0)) begin
            @(posedge clock);
            n++;
            if (n > budget) begin
                checks++;
                errors++;
                $display("FAIL %s lane%0d: timeout, got %0d bytes outstanding, want 0", name, l, qsize(l));
                return;
            end
        end
    endtask

    task automatic randomize_regs(int l);
        regs[l][0] = 32'h0;
        for (int r = 1; r < 32; r++) regs[l][r] = $urandom();
    endtask

    initial begin
        int base;
        int cyc;
        int n;
        ctrl_reset = 1'b1;
        for (int l = 0; l < NL; l++) begin
            start[l] = 1'b0;
            bp[l] = 1'b0;
            rx_count[l] = 0;
            done_due[l] = 0;
            held[l] = 1'b0;
            held_data[l] = 8'h00;
            for (int r = 0; r < 32; r++) regs[l][r] = 32'h0;
        end
        repeat (3) @(posedge clock);
        #1;
        for (int l = 0; l < NL; l++) begin
            check("rst_tx_valid", l, tx_valid[l], 1'b0);
            check("rst_tx_data", l, tx_data[l], 8'h00);
            check("rst_busy", l, busy[l], 1'b0);
            check("rst_done", l, done[l], 1'b0);
            check("rst_readReg", l, rd_addr[l], 5'd0);
        end
        @(posedge clock);
        #1;
        ctrl_reset = 1'b0;

        // Single register, ready tied high: A1 DE AD BE EF 83
        regs[0][1] = 32'hDEADBEEF;
        base = rx_count[0];
        pulse_start(0, 1'b1);
        wait_quiet(0, 200, "frame_one");
        check("frame_one_len", 0, rx_count[0] - base, 6);

        // Regfile write after capture, plus a start pulse during DATA
        base = rx_count[0];
        pulse_start(0, 1'b1);
        @(posedge clock);
        #1;
        regs[0][1] = 32'h12345678;
        pulse_start(0, 1'b0);
        wait_quiet(0, 200, "frame_snap");
        check("frame_snap_len", 0, rx_count[0] - base, 6);
        regs[0][1] = 32'hDEADBEEF;

        // Backpressure: same sequence, then random values
        bp[0] = 1'b1;
        pulse_start(0, 1'b1);
        wait_quiet(0, 500, "frame_bp");
        for (int i = 0; i < 3; i++) begin
            regs[0][1] = $urandom();
            pulse_start(0, 1'b1);
            wait_quiet(0, 500, "frame_bp_rand");
        end

        // Default parameters, ramp pattern, ready high
        for (int r = 0; r < 32; r++) regs[1][r] = 32'(r) * 32'h01010101;
        base = rx_count[1];
        pulse_start(1, 1'b1);
        cyc = 0;
        n = 0;
        while (n < 1000) begin
            @(negedge clock);
            n++;
            if (done[1]) break;
            if (busy[1]) cyc++;
        end
        check("dump_busy_cycles", 1, cyc, 193);
        wait_quiet(1, 400, "frame_all");
        check("frame_all_len", 1, rx_count[1] - base, 161);

        // Random contents with backpressure
        bp[1] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            randomize_regs(1);
            pulse_start(1, 1'b1);
            wait_quiet(1, 3000, "frame_all_bp");
        end

        // Asynchronous reset in the middle of a data burst
        bp[1] = 1'b0;
        randomize_regs(1);
        base = rx_count[1];
        pulse_start(1, 1'b1);
        n = 0;
        while (rx_count[1] < base + 7 && n < 100) begin
            @(negedge clock);
            n++;
        end
        @(posedge clock);
        #1;
        check("busy_before_reset", 1, busy[1], 1'b1);
        #1;
        ctrl_reset = 1'b1;
        #1;
        check("async_tx_valid", 1, tx_valid[1], 1'b0);
        check("async_busy", 1, busy[1], 1'b0);
        check("async_readReg", 1, rd_addr[1], 5'd0);
        check("async_tx_data", 1, tx_data[1], 8'h00);
        @(negedge clock);
        @(posedge clock);
        #1;
        ctrl_reset = 1'b0;

        // Fresh frames after reset
        bp[1] = 1'b1;
        randomize_regs(1);
        base = rx_count[1];
        pulse_start(1, 1'b1);
        wait_quiet(1, 3000, "frame_after_reset");
        check("frame_after_reset_len", 1, rx_count[1] - base, 161);
        regs[0][1] = 32'hDEADBEEF;
        base = rx_count[0];
        pulse_start(0, 1'b1);
        wait_quiet(0, 500, "frame_one_after_reset");
        check("frame_one_after_reset_len", 0, rx_count[0] - base, 6);

        repeat (5) @(posedge clock);
        check("queue0_empty", 0, qsize(0), 0);
        check("queue1_empty", 1, qsize(1), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
